// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, bounded hold time and
// bubble-free handoff between owners.
module onehot_rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDXW     = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic            gnt_valid,
    output logic [IDXW-1:0] gnt_idx,
    output logic            expired
);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            exp_q, exp_d;

    logic            do_grant;
    logic            go_idle;
    logic [IDXW-1:0] win;
    logic [N-1:0]    req_others;

    function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] k);
        return (k == IDXW'(N - 1)) ? '0 : k + 1'b1;
    endfunction

    // First set bit of r, searching circularly upward from start.
    function automatic logic [IDXW-1:0] pick(input logic [N-1:0] r, input logic [IDXW-1:0] start);
        logic [IDXW-1:0] res;
        logic            found;
        int              pos;
        res   = '0;
        found = 1'b0;
        for (int o = 0; o < N; o++) begin
            pos = int'(start) + o;
            if (pos >= N) pos = pos - N;
            if (!found && r[pos]) begin
                found = 1'b1;
                res   = IDXW'(pos);
            end
        end
        return res;
    endfunction

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        exp_d      = 1'b0;
        do_grant   = 1'b0;
        go_idle    = 1'b0;
        win        = '0;
        req_others = req & ~gnt_q;

        case (state_q)
            IDLE: begin
                if (en && |req) begin
                    do_grant = 1'b1;
                    win      = pick(req, ptr_q);
                end
            end
            GRANT: begin
                if (!req[idx_q]) begin
                    // Release wins over a coincident expiry.
                    if (en && |req_others) begin
                        do_grant = 1'b1;
                        win      = pick(req_others, next_idx(idx_q));
                    end else begin
                        go_idle = 1'b1;
                    end
                end else if (|req_others) begin
                    if (hold_q == HW'(MAX_HOLD)) begin
                        if (en) begin
                            do_grant = 1'b1;
                            win      = pick(req_others, next_idx(idx_q));
                            exp_d    = 1'b1;
                        end else begin
                            go_idle = 1'b1;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end else if (hold_q != HW'(MAX_HOLD)) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (do_grant) begin
            gnt_d      = '0;
            gnt_d[win] = 1'b1;
            idx_d      = win;
            ptr_d      = next_idx(win);
            hold_d     = HW'(1);
            state_d    = GRANT;
        end else if (go_idle) begin
            gnt_d   = '0;
            idx_d   = '0;
            state_d = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            exp_q   <= exp_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = (state_q == GRANT);
    assign gnt_idx   = idx_q;
    assign expired   = exp_q;
endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Scoreboard bench for onehot_rr_arbiter: per-cycle expected grant/expiry
// values are queued with the stimulus and compared one cycle later.
module tb_onehot_rr_arbiter;
    localparam int N        = 4;
    localparam int MAX_HOLD = 8;
    localparam int IDXW     = $clog2(N);
    localparam int BOUND    = (N - 1) * MAX_HOLD + 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [N-1:0]    req;
    logic [N-1:0]    gnt;
    logic            gnt_valid;
    logic [IDXW-1:0] gnt_idx;
    logic            expired;

    typedef struct {
        logic [N-1:0] gnt;
        logic         expired;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   wait_cnt[N];

    onehot_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .expired   (expired)
    );

    always #5 clk = ~clk;

    // Invariant monitor: one-hot grant, index consistency, bounded waiting.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (gnt_valid && !$onehot(gnt)) begin
                failures++;
                $display("FAIL inv_onehot: gnt=%b with gnt_valid=1", gnt);
            end
            if (!gnt_valid && gnt != '0) begin
                failures++;
                $display("FAIL inv_zero: gnt=%b with gnt_valid=0", gnt);
            end
            if (gnt_valid && !gnt[gnt_idx]) begin
                failures++;
                $display("FAIL inv_idx: gnt=%b gnt_idx=%0d", gnt, gnt_idx);
            end
            for (int i = 0; i < N; i++) begin
                if (en && req[i] && !gnt[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                if (wait_cnt[i] > BOUND) begin
                    failures++;
                    $display("FAIL inv_starve: req[%0d] waited %0d cycles, limit %0d", i, wait_cnt[i], BOUND);
                    wait_cnt[i] = 0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        end
    end

    task automatic expect_next(input logic [N-1:0] g, input logic e, input string name);
        exp_t x;
        x.gnt     = g;
        x.expired = e;
        x.name    = name;
        sb.push_back(x);
    endtask

    // Advance one edge, then compare the DUT against the oldest queued entry.
    task automatic tick();
        exp_t            x;
        logic [IDXW-1:0] want_idx;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_empty: no expectation queued for this cycle");
            return;
        end
        x = sb.pop_front();
        want_idx = '0;
        for (int i = 0; i < N; i++) if (x.gnt[i]) want_idx = IDXW'(i);
        checks++;
        if (gnt !== x.gnt) begin
            failures++;
            $display("FAIL %s gnt: got %b want %b", x.name, gnt, x.gnt);
        end
        checks++;
        if (gnt_valid !== (|x.gnt)) begin
            failures++;
            $display("FAIL %s gnt_valid: got %b want %b", x.name, gnt_valid, |x.gnt);
        end
        checks++;
        if (expired !== x.expired) begin
            failures++;
            $display("FAIL %s expired: got %b want %b", x.name, expired, x.expired);
        end
        if (x.gnt != '0) begin
            checks++;
            if (gnt_idx !== want_idx) begin
                failures++;
                $display("FAIL %s gnt_idx: got %0d want %0d", x.name, gnt_idx, want_idx);
            end
        end
    endtask

    task automatic step(input logic [N-1:0] g, input logic e, input string name);
        expect_next(g, e, name);
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        step('0, 1'b0, "reset");
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        req   = 4'b1111;
        step('0, 1'b0, "reset_c1");
        step('0, 1'b0, "reset_c2");
        checks++;
        if (gnt_idx !== '0) begin
            failures++;
            $display("FAIL reset gnt_idx: got %0d want 0", gnt_idx);
        end
    endtask

    task automatic test_release();
        rst_n = 1'b1;
        req   = '0;
        en    = 1'b1;
        step('0, 1'b0, "rel_idle");
        req = 4'b0101;
        step(4'b0001, 1'b0, "rel_first");
        req = 4'b0100;
        step(4'b0100, 1'b0, "rel_handoff");
        req = '0;
        step('0, 1'b0, "rel_drop");
        step('0, 1'b0, "rel_idle2");
    endtask

    task automatic test_expiry();
        logic [N-1:0] seq [5];
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
        seq[3] = 4'b1000; seq[4] = 4'b0001;
        do_reset();
        en  = 1'b1;
        req = 4'b1111;
        for (int s = 0; s < 5; s++)
            for (int c = 0; c < MAX_HOLD; c++)
                step(seq[s], (s > 0 && c == 0), "expiry_rotate");
        // Owner 0 releases exactly when its hold expires: release, no pulse.
        req = 4'b1110;
        step(4'b0010, 1'b0, "expiry_vs_release");
        req = '0;
        step('0, 1'b0, "expiry_drain");
    endtask

    task automatic test_sole();
        do_reset();
        en  = 1'b1;
        req = 4'b0100;
        for (int c = 0; c < 20; c++) step(4'b0100, 1'b0, "sole_hold");
        checks++;
        if (dut.hold_q !== 4'd8) begin
            failures++;
            $display("FAIL sole hold_cnt: got %0d want 8", dut.hold_q);
        end
        req = '0;
        step('0, 1'b0, "sole_drop");
    endtask

    task automatic test_en_drop();
        do_reset();
        en  = 1'b1;
        req = 4'b0010;
        step(4'b0010, 1'b0, "en_grant");
        en  = 1'b0;
        req = 4'b1011;
        for (int c = 0; c < 3; c++) step(4'b0010, 1'b0, "en_keep");
        req = 4'b1001;
        step('0, 1'b0, "en_release");
        for (int c = 0; c < 3; c++) step('0, 1'b0, "en_blocked");
        en = 1'b1;
        step(4'b1000, 1'b0, "en_resume");
        req = '0;
        step('0, 1'b0, "en_drain");
    endtask

    task automatic test_mid_reset();
        do_reset();
        en  = 1'b1;
        req = 4'b0001;
        step(4'b0001, 1'b0, "mid_grant");
        step(4'b0001, 1'b0, "mid_hold");
        rst_n = 1'b0;
        step('0, 1'b0, "mid_reset");
        rst_n = 1'b1;
        req   = 4'b1100;
        step(4'b0100, 1'b0, "mid_ptr0");
        req = '0;
        step('0, 1'b0, "mid_drain");
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        req   = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        @(negedge clk);
        test_reset();
        test_release();
        test_expiry();
        test_sole();
        test_en_drop();
        test_mid_reset();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: %0d entries left, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
